// File: rtl/vga_drawer_pkg.sv
`default_nettype none
// =============================================================================
//  Module      : vga_drawer_pkg
//  Description : Shared sizes, 640x480 VGA timing constants and small helpers
//                for the image-compare / display block.
//  Revision    : 1.0 - initial release
// =============================================================================
package vga_drawer_pkg;

    localparam logic [9:0] H_VISIBLE    = 10'd640;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_SYNC_END   = 10'd751;
    localparam logic [9:0] H_TOTAL      = 10'd800;
    localparam logic [9:0] V_VISIBLE    = 10'd480;
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] V_SYNC_END   = 10'd491;
    localparam logic [9:0] V_TOTAL      = 10'd525;
    localparam logic [9:0] TILE_W       = 10'd160;
    localparam logic [9:0] TILE_H       = 10'd120;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int PIX_W  = 24;

    typedef logic [PIX_W-1:0] pixel_t;

    // Tile index 0..3; anything past the third boundary clamps to 3.
    function automatic logic [1:0] tile_index(input logic [9:0] pos, input logic [9:0] size);
        if (pos < size)                    return 2'd0;
        else if (pos < size + size)        return 2'd1;
        else if (pos < size + size + size) return 2'd2;
        else                               return 2'd3;
    endfunction

    function automatic logic [7:0] abs_diff8(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_drawer_timing.sv
`default_nettype none
// =============================================================================
//  Module      : vga_timing
//  Description : 25 MHz pixel phase, 800x525 scan counters, syncs, visible flag.
//  Revision    : 1.0 - initial release
// =============================================================================
module vga_timing
    import vga_drawer_pkg::*;
(
    input  logic       clk50,
    input  logic       reset,
    output logic       phase,
    output logic [9:0] counter_x,
    output logic [9:0] counter_y,
    output logic       in_display,
    output logic       h_sync,
    output logic       v_sync
);

    always_ff @(posedge clk50) begin
        if (reset) begin
            phase     <= 1'b0;
            counter_x <= '0;
            counter_y <= '0;
        end else begin
            phase <= ~phase;
            if (phase) begin
                if (counter_x == H_TOTAL - 10'd1) begin
                    counter_x <= '0;
                    counter_y <= (counter_y == V_TOTAL - 10'd1) ? '0 : counter_y + 10'd1;
                end else begin
                    counter_x <= counter_x + 10'd1;
                end
            end
        end
    end

    always_comb begin
        in_display = (counter_x < H_VISIBLE) && (counter_y < V_VISIBLE);
        h_sync     = ~((counter_x >= H_SYNC_START) && (counter_x <= H_SYNC_END));
        v_sync     = ~((counter_y >= V_SYNC_START) && (counter_y <= V_SYNC_END));
    end

endmodule
`default_nettype wire

// File: rtl/vga_drawer.sv
`default_nettype none
// =============================================================================
//  Module      : vga_drawer
//  Description : Two host-loaded pixel buffers, per-channel |difference| into a
//                third buffer, scanned out as a 4x4 tiled 640x480 VGA image.
//  Revision    : 1.0 - initial release
// =============================================================================
module vga_drawer
    import vga_drawer_pkg::*;
(
    input  logic              clk50,
    input  logic              reset,
    input  logic              enable,
    input  logic [ADDR_W-1:0] address,
    input  logic              wren1,
    input  logic [PIX_W-1:0]  data1,
    output logic [PIX_W-1:0]  q1,
    input  logic              wren2,
    input  logic [PIX_W-1:0]  data2,
    output logic [PIX_W-1:0]  q2,
    input  logic              wren3,
    output logic [PIX_W-1:0]  data3,
    output logic [PIX_W-1:0]  q3,
    output logic [9:0]        CounterX,
    output logic [9:0]        CounterY,
    output logic              inDisplayArea,
    output logic              dataReady,
    output logic              vga_h_sync,
    output logic              vga_v_sync,
    output logic [7:0]        vga_R,
    output logic [7:0]        vga_G,
    output logic [7:0]        vga_B
);

    pixel_t            buf1 [DEPTH];
    pixel_t            buf2 [DEPTH];
    pixel_t            buf3 [DEPTH];
    logic              phase;
    logic              show;
    logic              host_wr;
    logic [ADDR_W-1:0] scan_addr;
    logic [ADDR_W-1:0] active_addr;

    vga_timing u_timing (
        .clk50      (clk50),
        .reset      (reset),
        .phase      (phase),
        .counter_x  (CounterX),
        .counter_y  (CounterY),
        .in_display (inDisplayArea),
        .h_sync     (vga_h_sync),
        .v_sync     (vga_v_sync)
    );

    assign scan_addr   = {tile_index(CounterY, TILE_H), tile_index(CounterX, TILE_W)};
    assign active_addr = enable ? scan_addr : address;
    assign host_wr     = ~enable;

    // Buffers hold their contents through reset; only the read registers clear.
    always_ff @(posedge clk50) begin
        if (host_wr && wren1) buf1[address] <= data1;
        if (host_wr && wren2) buf2[address] <= data2;
        if (host_wr && wren3) buf3[address] <= data3;
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            q1 <= '0;
            q2 <= '0;
            q3 <= '0;
        end else begin
            q1 <= buf1[active_addr];
            q2 <= buf2[active_addr];
            q3 <= buf3[active_addr];
        end
    end

    for (genvar b = 0; b < PIX_W / 8; b++) begin : g_byte
        assign data3[8*b +: 8] = abs_diff8(q1[8*b +: 8], q2[8*b +: 8]);
    end

    assign show                  = enable & inDisplayArea;
    assign dataReady             = show & phase;
    assign {vga_R, vga_G, vga_B} = show ? q3 : '0;

endmodule
`default_nettype wire

// File: tb/tb_vga_drawer.sv
`default_nettype none
// =============================================================================
//  Module      : tb_vga_drawer
//  Description : Randomized self-checking bench with an arithmetic scan model.
//  Revision    : 1.0 - initial release
// =============================================================================
module tb_vga_drawer;

    logic        clk50 = 1'b0;
    logic        reset, enable, wren1, wren2, wren3;
    logic [3:0]  address;
    logic [23:0] data1, data2, data3, q1, q2, q3;
    logic [9:0]  CounterX, CounterY;
    logic        inDisplayArea, dataReady, vga_h_sync, vga_v_sync;
    logic [7:0]  vga_R, vga_G, vga_B;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: buffer images with written-flags, read registers, edges since reset.
    logic [23:0] m1 [16];
    logic [23:0] m2 [16];
    logic [23:0] m3 [16];
    bit          v1 [16];
    bit          v2 [16];
    bit          v3 [16];
    logic [23:0] mq1, mq2, mq3;
    bit          k1, k2, k3;
    int          n_edges = 0;

    always #10 clk50 = ~clk50;

    vga_drawer dut (
        .clk50(clk50), .reset(reset), .enable(enable), .address(address),
        .wren1(wren1), .data1(data1), .q1(q1),
        .wren2(wren2), .data2(data2), .q2(q2),
        .wren3(wren3), .data3(data3), .q3(q3),
        .CounterX(CounterX), .CounterY(CounterY), .inDisplayArea(inDisplayArea),
        .dataReady(dataReady), .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync),
        .vga_R(vga_R), .vga_G(vga_G), .vga_B(vga_B)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int mx();
        return (n_edges / 2) % 800;
    endfunction

    function automatic int my();
        return (n_edges / 1600) % 525;
    endfunction

    function automatic int scan_of(input int x, input int y);
        int r, c;
        r = y / 120; if (r > 3) r = 3;
        c = x / 160; if (c > 3) c = 3;
        return r * 4 + c;
    endfunction

    function automatic logic [23:0] diff_of(input logic [23:0] a, input logic [23:0] b);
        logic [23:0] d;
        for (int i = 0; i < 3; i++) begin
            int x, y;
            x = int'(a[8*i +: 8]);
            y = int'(b[8*i +: 8]);
            d[8*i +: 8] = 8'((x > y) ? x - y : y - x);
        end
        return d;
    endfunction

    task automatic model_edge();
        int a;
        logic [23:0] d3, n1, n2, n3;
        bit d3k, nk1, nk2, nk3;
        if (reset) begin
            n_edges = 0;
            mq1 = '0; mq2 = '0; mq3 = '0;
            k1 = 1; k2 = 1; k3 = 1;
            return;
        end
        a   = enable ? scan_of(mx(), my()) : int'(address);
        d3  = diff_of(mq1, mq2);
        d3k = k1 && k2;
        n1 = m1[a]; nk1 = v1[a];
        n2 = m2[a]; nk2 = v2[a];
        n3 = m3[a]; nk3 = v3[a];
        if (!enable) begin
            if (wren1) begin m1[address] = data1; v1[address] = 1; end
            if (wren2) begin m2[address] = data2; v2[address] = 1; end
            if (wren3) begin m3[address] = d3;    v3[address] = d3k; end
        end
        mq1 = n1; k1 = nk1;
        mq2 = n2; k2 = nk2;
        mq3 = n3; k3 = nk3;
        n_edges++;
    endtask

    task automatic check_outputs();
        int  x, y;
        bit  disp, show;
        x    = mx();
        y    = my();
        disp = (x < 640) && (y < 480);
        show = enable && disp;
        check("CounterX", 32'(CounterX), 32'(x));
        check("CounterY", 32'(CounterY), 32'(y));
        check("inDisplayArea", 32'(inDisplayArea), 32'(disp));
        check("h_sync", 32'(vga_h_sync), 32'(!(x >= 656 && x <= 751)));
        check("v_sync", 32'(vga_v_sync), 32'(!(y >= 490 && y <= 491)));
        check("dataReady", 32'(dataReady), 32'(show && (n_edges % 2 == 1)));
        if (k1) check("q1", 32'(q1), 32'(mq1));
        if (k2) check("q2", 32'(q2), 32'(mq2));
        if (k3) check("q3", 32'(q3), 32'(mq3));
        if (k1 && k2) check("data3", 32'(data3), 32'(diff_of(mq1, mq2)));
        if (!show)    check("rgb_blank", 32'({vga_R, vga_G, vga_B}), 32'd0);
        else if (k3)  check("rgb", 32'({vga_R, vga_G, vga_B}), 32'(mq3));
    endtask

    task automatic step();
        @(posedge clk50);
        model_edge();
        @(negedge clk50);
        check_outputs();
    endtask

    initial begin
        int hlow, vlow, cyc;
        bit found;
        reset = 1; enable = 0; address = '0;
        wren1 = 0; wren2 = 0; wren3 = 0; data1 = '0; data2 = '0;
        for (int i = 0; i < 16; i++) begin v1[i] = 0; v2[i] = 0; v3[i] = 0; end

        @(negedge clk50);
        step(); step();
        check("reset_rgb", 32'({vga_R, vga_G, vga_B}), 32'd0);
        check("reset_syncs", 32'({vga_h_sync, vga_v_sync}), 32'h3);
        reset = 0;

        // Load loop: one address per clock into buffers 1 and 2.
        for (int i = 0; i < 16; i++) begin
            address = 4'(i); wren1 = 1; wren2 = 1;
            data1 = 24'h102030 + 24'(i); data2 = 24'h0F3F20;
            step();
        end
        wren1 = 0; wren2 = 0;

        // Compare pass: hold each address two cycles with wren3 high.
        for (int i = 0; i < 16; i++) begin
            address = 4'(i); wren3 = 1;
            step(); step();
            check("cmp_data3", 32'(data3), 32'(24'h011F10 + 24'(i)));
        end
        wren3 = 0;

        address = 4'd0; wren1 = 1; wren2 = 1; data1 = 24'h00FF00; data2 = 24'hFF0000;
        step();
        wren1 = 0; wren2 = 0; wren3 = 1;
        step(); step();
        check("cmp_ffff00", 32'(data3), 32'hFFFF00);
        wren3 = 0;

        // Randomized host traffic with display mode toggled (writes must be blocked).
        for (int i = 0; i < 400; i++) begin
            enable  = (i >= 200) ? 1'($urandom_range(0, 1)) : 1'b0;
            address = 4'($urandom);
            wren1 = 1'($urandom); wren2 = 1'($urandom); wren3 = 1'($urandom);
            data1 = 24'($urandom); data2 = 24'($urandom);
            step();
        end
        enable = 0; wren1 = 0; wren2 = 0; wren3 = 0;

        // Tile (row0,col1) and (row1,col1) show 0xAABBCC.
        for (int t = 1; t <= 5; t += 4) begin
            address = 4'(t); wren1 = 1; wren2 = 1; data1 = 24'hAABBCC; data2 = 24'h000000;
            step();
            wren1 = 0; wren2 = 0; wren3 = 1;
            step(); step();
            wren3 = 0;
        end

        // Blocked-write readback: enable=1 with wren1 must not disturb buffer 1.
        enable = 1; wren1 = 1; data1 = 24'h5A5A5A;
        for (int i = 0; i < 16; i++) begin address = 4'(i); step(); end
        wren1 = 0; enable = 0;
        for (int i = 0; i < 16; i++) begin address = 4'(i); step(); end

        // Timing with enable=0 from a fresh reset: one full line plus one pixel.
        reset = 1; step(); reset = 0;
        hlow = 0; vlow = 0;
        for (int i = 0; i < 1600; i++) begin
            step();
            if (!vga_h_sync) hlow++;
            if (!vga_v_sync) vlow++;
        end
        check("hsync_low_pixels", 32'(hlow / 2), 32'd96);
        check("vsync_low_early", 32'(vlow), 32'd0);
        check("line_wrap_y", 32'(CounterY), 32'd1);

        // Display mode: run past X=200 in a tile holding 0xAABBCC.
        reset = 1; step(); reset = 0; enable = 1;
        found = 0;
        for (cyc = 0; cyc < 4000 && !found; cyc++) begin
            step();
            if (CounterX == 10'd200 && dataReady) found = 1;
        end
        check("wait_x200", 32'(found), 32'd1);
        check("disp_R", 32'(vga_R), 32'hAA);
        check("disp_G", 32'(vga_G), 32'hBB);
        check("disp_B", 32'(vga_B), 32'hCC);
        found = 0;
        for (cyc = 0; cyc < 4000 && !found; cyc++) begin
            step();
            if (CounterX == 10'd700) found = 1;
        end
        check("wait_x700", 32'(found), 32'd1);
        check("blank_rgb_700", 32'({vga_R, vga_G, vga_B}), 32'd0);
        check("blank_rdy_700", 32'(dataReady), 32'd0);
        for (int i = 0; i < 3300; i++) step();

        // Reset mid-frame at X=300.
        found = 0;
        for (cyc = 0; cyc < 4000 && !found; cyc++) begin
            step();
            if (CounterX == 10'd300) found = 1;
        end
        check("wait_x300", 32'(found), 32'd1);
        reset = 1; step(); reset = 0;
        check("midrst_x", 32'(CounterX), 32'd0);
        check("midrst_y", 32'(CounterY), 32'd0);
        check("midrst_syncs", 32'({vga_h_sync, vga_v_sync}), 32'h3);
        check("midrst_rgb", 32'({vga_R, vga_G, vga_B}), 32'd0);
        enable = 0;
        for (int i = 0; i < 17; i++) begin address = 4'(i % 16); step(); end
        address = 4'd1; step(); step();
        check("buf3_kept", 32'(q3), 32'hAABBCC);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
